// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/sub sequencer: FSM encoding and slice width.
package nibble_serial_addsub_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Operand/result handshake bundle between a producer/consumer (master) and the sequencer (slave).
interface nibble_serial_addsub_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow
  );

endinterface

// File: rtl/nibble_serial_addsub_ctrl_addsub4.sv
// 4-bit ripple-carry adder slice; the caller pre-inverts b and sets carry-in for subtraction.
module nibble_serial_addsub_ctrl_addsub4
  import nibble_serial_addsub_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// Computes WIDTH-bit A+B / A-B one nibble per cycle, LSB first, through a single shared 4-bit slice.
module nibble_serial_addsub_ctrl
  import nibble_serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                        clk,
  input logic                        rst_n,
  nibble_serial_addsub_ctrl_if.slave bus
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int SW  = $clog2(NIB);
  localparam logic [SW-1:0] LAST = SW'(NIB - 1);

  state_t state, state_nxt;

  logic [NIB-1:0][NIBBLE_W-1:0] a_reg;
  logic [NIB-1:0][NIBBLE_W-1:0] b_reg;
  logic [NIB-1:0][NIBBLE_W-1:0] res_reg;
  logic                         sub_reg;
  logic                         carry_reg;
  logic                         carry_out_reg;
  logic                         overflow_reg;
  logic [SW-1:0]                step;

  logic                accept;
  logic                last_step;
  logic                in_ready_c;
  logic                out_valid_c;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] sum_nib;
  logic                slice_cout;

  function automatic logic signed_overflow(input logic sign_a, input logic sign_b,
                                           input logic sign_r);
    return (sign_a == sign_b) && (sign_r != sign_a);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign last_step = (step == LAST);

  // Nibble select and B inversion ahead of the shared slice
  assign a_nib = a_reg[step];
  assign b_nib = b_reg[step] ^ {NIBBLE_W{sub_reg}};

  nibble_serial_addsub_ctrl_addsub4 u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_reg),
    .sum  (sum_nib),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      res_reg       <= '0;
      sub_reg       <= 1'b0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      step          <= '0;
    end else if (accept) begin
      a_reg     <= bus.op_a;
      b_reg     <= bus.op_b;
      sub_reg   <= bus.sub;
      carry_reg <= bus.sub;
      step      <= '0;
    end else if (state == RUN) begin
      res_reg[step] <= sum_nib;
      carry_reg     <= slice_cout;
      // Flags are captured from the top nibble so they are ready the cycle DONE is entered
      if (last_step) begin
        carry_out_reg <= slice_cout;
        overflow_reg  <= signed_overflow(a_nib[NIBBLE_W-1], b_nib[NIBBLE_W-1],
                                         sum_nib[NIBBLE_W-1]);
      end else begin
        step <= step + 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.result    = res_reg;
  assign bus.carry_out = carry_out_reg;
  assign bus.overflow  = overflow_reg;

endmodule
